// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide sequencer that owns the architectural HI/LO registers.
// Uses a shift-add multiply and a restoring divide on operand magnitudes, one bit per cycle.
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] op_x,
  input  logic [WIDTH-1:0] op_y,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic             r_isDiv;
  logic             r_negRes;
  logic             r_negRem;
  logic             r_dbz;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_dbzOut;

  logic             w_signed;
  logic             w_xNeg;
  logic             w_yNeg;
  logic [WIDTH-1:0] w_absX;
  logic [WIDTH-1:0] w_absY;
  logic [WIDTH:0]   w_mulSum;
  logic [WIDTH:0]   w_shifted;
  logic             w_qBit;
  logic [WIDTH-1:0] w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_hiNext;
  logic [WIDTH-1:0] w_loNext;

  always_comb begin
    w_signed = ~md_op[0];
    w_xNeg   = w_signed & op_x[WIDTH-1];
    w_yNeg   = w_signed & op_y[WIDTH-1];
    w_absX   = w_xNeg ? -op_x : op_x;
    w_absY   = w_yNeg ? -op_y : op_y;

    // Multiply: add the multiplicand into the upper half when the low bit of the multiplier is set.
    w_mulSum = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});

    // Divide: the trial difference always fits WIDTH bits when it is kept, so modular subtraction suffices.
    w_shifted = {r_rem, r_q[WIDTH-1]};
    w_qBit    = (w_shifted >= {1'b0, r_b});
    w_diff    = w_shifted[WIDTH-1:0] - r_b;

    w_prod   = {r_rem, r_q};
    w_hiNext = '0;
    w_loNext = '0;
    if (!r_isDiv) begin
      if (r_negRes) begin
        w_prod = -w_prod;
      end
      w_hiNext = w_prod[2*WIDTH-1:WIDTH];
      w_loNext = w_prod[WIDTH-1:0];
    end else if (r_dbz) begin
      w_hiNext = r_negRem ? -r_a : r_a;
      w_loNext = '1;
    end else begin
      w_hiNext = r_negRem ? -r_rem : r_rem;
      w_loNext = r_negRes ? -r_q : r_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_isDiv  <= 1'b0;
      r_negRes <= 1'b0;
      r_negRem <= 1'b0;
      r_dbz    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbzOut <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_dbzOut <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state  <= S_RUN;
              r_busy   <= 1'b1;
              r_count  <= '0;
              r_isDiv  <= md_op[1];
              r_negRes <= w_xNeg ^ w_yNeg;
              r_negRem <= w_xNeg;
              r_dbz    <= md_op[1] & (op_y == '0);
              r_a      <= w_absX;
              r_b      <= w_absY;
              r_rem    <= '0;
              r_q      <= md_op[1] ? w_absX : w_absY;
            end else begin
              if (hi_we) r_hi <= wr_data;
              if (lo_we) r_lo <= wr_data;
            end
          end
          S_RUN: begin
            if (r_isDiv) begin
              r_rem <= w_qBit ? w_diff : w_shifted[WIDTH-1:0];
              r_q   <= {r_q[WIDTH-2:0], w_qBit};
            end else begin
              r_rem <= w_mulSum[WIDTH:1];
              r_q   <= {w_mulSum[0], r_q[WIDTH-1:1]};
            end
            r_count <= r_count + 1'b1;
            if (r_count == CW'(WIDTH-1)) begin
              r_state <= S_FIX;
            end
          end
          S_FIX: begin
            r_hi     <= w_hiNext;
            r_lo     <= w_loNext;
            r_done   <= 1'b1;
            r_dbzOut <= r_dbz;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbzOut;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer: a table of mul/div vectors
// plus hand-written sequences for back-to-back issue, flush, HI/LO writes and reset.
module tb_mdu_sequencer;

  localparam int WIDTH = 32;
  localparam int LIMIT = WIDTH + 20;

  logic             clk;
  logic             rst;
  logic             start;
  logic [1:0]       md_op;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wr_data;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int numCompared;
  int numMismatched;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDbz;
  } vec_t;

  vec_t vecs[9];

  mdu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .md_op(md_op),
    .op_x(op_x),
    .op_y(op_y),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .wr_data(wr_data),
    .flush(flush),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .hi(hi),
    .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    numCompared++;
    if (act !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives start for one cycle and returns at the negedge where done is seen.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                               output int lat, output int busyErr);
    start = 1'b1;
    md_op = op;
    op_x  = x;
    op_y  = y;
    @(negedge clk);
    start   = 1'b0;
    lat     = 1;
    busyErr = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      if (busy !== 1'b1) busyErr++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int busyErr;
    int doneSeen;

    numCompared   = 0;
    numMismatched = 0;
    rst     = 1'b1;
    start   = 1'b0;
    md_op   = 2'b00;
    op_x    = '0;
    op_y    = '0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    wr_data = '0;
    flush   = 1'b0;

    vecs[0] = '{"mult_7_m3",      2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1] = '{"div_m7_2",       2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[2] = '{"div_min_m1",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[3] = '{"divu_100_0",     2'b11, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[4] = '{"mult_m4_m5",     2'b00, 32'hFFFFFFFC, 32'hFFFFFFFB, 32'h00000000, 32'h00000014, 1'b0};
    vecs[5] = '{"div_7_m2",       2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[6] = '{"divu_big_16",    2'b11, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vecs[7] = '{"mult_min_min",   2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[8] = '{"div_m8_0",       2'b10, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_hi", {32'd0, hi}, 64'd0);
    checkOutput("reset_lo", {32'd0, lo}, 64'd0);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_dbz", {63'd0, div_by_zero}, 64'd0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].op, vecs[i].x, vecs[i].y, lat, busyErr);
      $display("[TB] vector %s latency %0d", vecs[i].name, lat);
      checkOutput({vecs[i].name, "_latency"}, 64'(lat), 64'(WIDTH + 2));
      checkOutput({vecs[i].name, "_busyGaps"}, 64'(busyErr), 64'd0);
      checkOutput({vecs[i].name, "_busyAtDone"}, {63'd0, busy}, 64'd0);
      checkOutput({vecs[i].name, "_hi"}, {32'd0, hi}, {32'd0, vecs[i].expHi});
      checkOutput({vecs[i].name, "_lo"}, {32'd0, lo}, {32'd0, vecs[i].expLo});
      checkOutput({vecs[i].name, "_dbz"}, {63'd0, div_by_zero}, {63'd0, vecs[i].expDbz});
      @(negedge clk);
      checkOutput({vecs[i].name, "_donePulse"}, {63'd0, done}, 64'd0);
      checkOutput({vecs[i].name, "_dbzPulse"}, {63'd0, div_by_zero}, 64'd0);
    end

    // Back-to-back: second start issued in the done cycle of the first.
    applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, busyErr);
    checkOutput("multu_max_latency", 64'(lat), 64'(WIDTH + 2));
    checkOutput("multu_max_prod", {hi, lo}, 64'hFFFFFFFE_00000001);
    applyStimulus(2'b11, 32'd100, 32'd7, lat, busyErr);
    checkOutput("chained_latency", 64'(lat), 64'(WIDTH + 2));
    checkOutput("chained_busyGaps", 64'(busyErr), 64'd0);
    checkOutput("chained_divu", {hi, lo}, {32'd2, 32'd14});
    @(negedge clk);

    // MTHI and a second start while busy must both be ignored.
    start = 1'b1; md_op = 2'b01; op_x = 32'd2; op_y = 32'd3;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < LIMIT) begin
      if (lat == 5) begin
        hi_we = 1'b1; wr_data = 32'hDEAD;
        start = 1'b1; md_op = 2'b11; op_x = 32'd9; op_y = 32'd0;
      end else begin
        hi_we = 1'b0; start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    hi_we = 1'b0; start = 1'b0;
    checkOutput("busyWrite_latency", 64'(lat), 64'(WIDTH + 2));
    checkOutput("busyWrite_result", {hi, lo}, {32'd0, 32'd6});
    checkOutput("busyWrite_dbz", {63'd0, div_by_zero}, 64'd0);
    @(negedge clk);

    // MTHI/MTLO preload in IDLE.
    hi_we = 1'b1; wr_data = 32'h11;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wr_data = 32'h22;
    @(negedge clk);
    lo_we = 1'b0;
    checkOutput("mthi", {32'd0, hi}, 64'h11);
    checkOutput("mtlo", {32'd0, lo}, 64'h22);

    // Start with a simultaneous MTHI (dropped), then flush at N+10.
    start = 1'b1; md_op = 2'b00; op_x = 32'd5; op_y = 32'd5;
    hi_we = 1'b1; wr_data = 32'h99;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("flush_busyBefore", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busyAfter", {63'd0, busy}, 64'd0);
    doneSeen = 0;
    for (int k = 0; k < WIDTH + 8; k++) begin
      if (done === 1'b1) doneSeen++;
      @(negedge clk);
    end
    checkOutput("flush_noDone", 64'(doneSeen), 64'd0);
    checkOutput("flush_hi", {32'd0, hi}, 64'h11);
    checkOutput("flush_lo", {32'd0, lo}, 64'h22);

    // Flush together with start in IDLE: start is ignored.
    start = 1'b1; flush = 1'b1; md_op = 2'b01; op_x = 32'd3; op_y = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checkOutput("flushStart_busy", {63'd0, busy}, 64'd0);
    doneSeen = 0;
    for (int k = 0; k < WIDTH + 4; k++) begin
      if (done === 1'b1) doneSeen++;
      @(negedge clk);
    end
    checkOutput("flushStart_noDone", 64'(doneSeen), 64'd0);
    checkOutput("flushStart_lo", {32'd0, lo}, 64'h22);

    // Reset mid-operation at N+5 clears everything.
    start = 1'b1; md_op = 2'b01; op_x = 32'd4; op_y = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midReset_hi", {32'd0, hi}, 64'd0);
    checkOutput("midReset_lo", {32'd0, lo}, 64'd0);
    checkOutput("midReset_busy", {63'd0, busy}, 64'd0);
    checkOutput("midReset_done", {63'd0, done}, 64'd0);
    checkOutput("midReset_dbz", {63'd0, div_by_zero}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
Multi-cycle multiply/divide sequencer for the MIPS core. It sits beside the single-cycle ALU and owns the architectural HI/LO registers. It serves MULT, MULTU, DIV, DIVU, MTHI and MTLO, and it asserts busy so the decode stage can stall any MFHI/MFLO or new mul/div operation. The datapath is iterative, one bit per cycle, using a shift-add multiply and a restoring divide on operand magnitudes.

Parameters:
WIDTH, 32, operand width. HI and LO are each WIDTH bits. The run phase lasts WIDTH cycles.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous active-high
start  input  1  launch the operation selected by md_op; sampled only when busy=0
md_op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
op_x  input  WIDTH  rs operand (multiplicand or dividend)
op_y  input  WIDTH  rt operand (multiplier or divisor)
hi_we  input  1  MTHI write strobe
lo_we  input  1  MTLO write strobe
wr_data  input  WIDTH  data for MTHI/MTLO
flush  input  1  exception/squash; aborts any in-flight operation
busy  output  1  operation in flight
done  output  1  one-cycle pulse: HI/LO updated by a completed op
div_by_zero  output  1  valid with done; high if the divisor was 0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE. Reset mid-operation discards the operation with no HI/LO update.
- States:
  - IDLE: the unit waits for work.
  - RUN: WIDTH iterations, tracked by count 0..WIDTH-1.
  - FIX: sign correction and writeback.
- IDLE -> RUN: start=1 at edge N. At that edge the unit latches md_op, |op_x| and |op_y| (the raw values for the unsigned ops), the result sign, and the dividend sign.
- RUN: one iteration per cycle over edges N+1..N+WIDTH. Multiply shifts and adds into a 2*WIDTH accumulator. Divide does a restoring shift-subtract into remainder and quotient.
- RUN -> FIX after the iteration with count=WIDTH-1.
- FIX -> IDLE at the next edge. That edge loads hi/lo and sets done=1 for exactly one cycle.
- busy=1 from the cycle after start through the FIX cycle. The result is visible at cycle N+WIDTH+2 (N+34 for the default), when done=1 and busy=0. A new start may be accepted in that same cycle.
- Result rules:
  - MULT/MULTU: {hi,lo} is the full 2*WIDTH product.
  - MULT: the product is negated when the operand signs differ.
  - DIV/DIVU: lo is the quotient and hi is the remainder.
  - DIV: the quotient is negative when the signs differ, and the remainder takes the sign of the dividend.
- Divide by zero: lo=all ones, hi=op_x unchanged, no sign correction, div_by_zero=1 with done. Latency is unchanged.
- DIV of MIN_INT by -1: lo=MIN_INT (the quotient wraps) and hi=0. No flag is raised.
- start while busy=1 is ignored. The issuer must stall on busy.
- hi_we/lo_we while busy=0: the register loads wr_data at the edge. Both strobes may be used together.
- hi_we/lo_we while busy=1: ignored.
- start together with hi_we or lo_we in IDLE: start wins and the write is dropped.
- flush in any state: next state is IDLE, busy=0 the next cycle, no done, and hi/lo keep their prior values.
- flush together with start in IDLE: start is ignored.
- flush together with the FIX cycle: flush wins and there is no update.
- done and div_by_zero are registered outputs and deassert the cycle after they assert.

Test Plan:
- MULT op_x=7, op_y=0xFFFFFFFD (-3) -> at N+34 done=1, busy=0, hi=0xFFFFFFFF, lo=0xFFFFFFEB. busy=1 exactly for cycles N+1..N+33.
- MULTU op_x=op_y=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. A second start issued at N+34 completes at N+68.
- DIV op_x=0xFFFFFFF9 (-7), op_y=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV op_x=0x80000000, op_y=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- DIVU op_x=100, op_y=0 -> lo=0xFFFFFFFF, hi=0x64, div_by_zero=1 for one cycle with done.
- Flush and HI/LO writes:
  - Preload hi=0x11, lo=0x22 via MTHI/MTLO, then start MULT 5*5 with flush at N+10 -> busy=0 at N+11, no done, hi=0x11, lo=0x22.
  - hi_we asserted during RUN -> ignored.
  - rst asserted at N+5 -> all outputs 0 at the next cycle.
